// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a FIFO of 2**FIFO_AW bytes feeds a serialiser. Writes are dropped while full.
// A byte written into an idle block is popped on the next edge. Back-to-back frames follow with no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_wr,
  input  logic [7:0]         tx_wdata,
  output logic               tbr_valid,
  input  logic               clr_ovrflw,
  output logic               tx_overflow,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               tx_busy,
  output logic               txd
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [1:0]         state;
  logic [15:0]        baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               bit_end;
  logic               push;
  logic               pop;

  assign bit_end     = (baud_cnt == BAUD_LAST);
  assign tbr_valid   = (count != FULL_COUNT);
  assign push        = tx_wr & tbr_valid;
  // The serialiser only pulls a byte when idle or at the last cycle of a stop bit.
  assign pop         = (count != '0) && ((state == IDLE) || ((state == STOP) && bit_end));
  assign fifo_count  = count;
  assign tx_busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped write outranks a same-cycle clear.
      if (tx_wr && !tbr_valid) tx_overflow <= 1'b1;
      else if (clr_ovrflw)     tx_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              txd   <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
